// File: rtl/run_detector_sequencer.sv
// Feeds a parallel word MSB-first into the shared 4-in-a-row run detector
// and collects hit count and first hit position from its z output.
module run_detector_sequencer #(
   parameter int WIDTH    = 16,
   parameter int TICK_DIV = 1,
   parameter int CNT_W    = 5
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic             det_z,
   output logic             det_w,
   output logic             det_step,
   output logic             det_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] first_hit,
   output logic             first_valid
);

   // state  | meaning
   // IDLE   | waiting for start edge, nothing loaded yet
   // CLEAR  | one-cycle detector clear
   // SHIFT  | present MSB on det_w, step on last tick
   // SAMPLE | read det_z, shift word, advance bit index
   // DONE   | results held until next start edge

   localparam int TDIV   = (TICK_DIV < 1) ? 1 : TICK_DIV;
   localparam int TICK_W = (TDIV > 1) ? $clog2(TDIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TDIV - 1);
   localparam logic [CNT_W-1:0]  IDX_LAST  = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic              start_q, start_d;
   logic              arm_q, arm_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  hit_q, hit_d;
   logic [CNT_W-1:0]  first_q, first_d;
   logic              fvalid_q, fvalid_d;
   logic              start_edge;

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         start_q  <= 1'b0;
         arm_q    <= 1'b0;
         tick_q   <= '0;
         idx_q    <= '0;
         hit_q    <= '0;
         first_q  <= '0;
         fvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         start_q  <= start_d;
         arm_q    <= arm_d;
         tick_q   <= tick_d;
         idx_q    <= idx_d;
         hit_q    <= hit_d;
         first_q  <= first_d;
         fvalid_q <= fvalid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      start_d  = start;
      // a start held through reset must be released before it can count
      arm_d    = arm_q | ~start;
      tick_d   = tick_q;
      idx_d    = idx_q;
      hit_d    = hit_q;
      first_d  = first_q;
      fvalid_d = fvalid_q;
      det_w    = 1'b0;
      det_step = 1'b0;
      det_clr  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      start_edge = start & ~start_q & arm_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            done = (state_q == S_DONE);
            if (start_edge) begin
               shift_d  = data_in;
               hit_d    = '0;
               first_d  = '0;
               fvalid_d = 1'b0;
               idx_d    = '0;
               state_d  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy    = 1'b1;
            det_clr = 1'b1;
            tick_d  = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            busy  = 1'b1;
            det_w = shift_q[WIDTH-1];
            if (tick_q == TICK_LAST) begin
               det_step = 1'b1;
               state_d  = S_SAMPLE;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         S_SAMPLE: begin
            busy = 1'b1;
            if (det_z) begin
               if (hit_q != CNT_MAX) hit_d = hit_q + CNT_W'(1);
               if (!fvalid_q) begin
                  first_d  = idx_q;
                  fvalid_d = 1'b1;
               end
            end
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + CNT_W'(1);
               tick_d  = '0;
               state_d = S_SHIFT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign hit_count   = hit_q;
   assign first_hit   = first_q;
   assign first_valid = fvalid_q;

endmodule

// File: tb/tb_run_detector_sequencer.sv
// Scoreboard bench: two sequencers (TICK_DIV 1 and 4), each driving a
// behavioural run detector; monitors compare steps, clears and results.
module tb_run_detector_sequencer;
   localparam int W = 16;

   typedef struct { int w; int cyc; } step_t;
   typedef struct { int hc; int fh; int fv; int cyc; } res_t;

   logic         clk = 1'b0;
   logic         aclr;
   logic         start_s[2];
   logic [W-1:0] data_s[2];
   logic         det_w_s[2], det_step_s[2], det_clr_s[2];
   logic         busy_s[2], done_s[2], fv_s[2];
   logic [4:0]   hc_s[2], fh_s[2];

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   step_t step_q[2][$];
   int    clr_q[2][$];
   res_t  res_q[2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_total++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int TD = (g == 0) ? 1 : 4;
      int   dst;
      logic det_z;
      logic done_prev = 1'b0;

      run_detector_sequencer #(.WIDTH(W), .TICK_DIV(TD), .CNT_W(5)) dut (
         .clk(clk), .aclr(aclr), .start(start_s[g]), .data_in(data_s[g]),
         .det_z(det_z), .det_w(det_w_s[g]), .det_step(det_step_s[g]),
         .det_clr(det_clr_s[g]), .busy(busy_s[g]), .done(done_s[g]),
         .hit_count(hc_s[g]), .first_hit(fh_s[g]), .first_valid(fv_s[g])
      );

      // detector: 0=A, 1..4 = run of zeros, 5..8 = run of ones; z in 4 or 8
      assign det_z = (dst == 4) || (dst == 8);
      always @(posedge clk or negedge aclr) begin
         if (!aclr) dst <= 0;
         else if (det_clr_s[g]) dst <= 0;
         else if (det_step_s[g]) begin
            if (det_w_s[g]) dst <= (dst >= 5 && dst < 8) ? dst + 1 : ((dst == 8) ? 8 : 5);
            else            dst <= (dst >= 1 && dst < 4) ? dst + 1 : ((dst == 4) ? 4 : 1);
         end
      end

      always @(negedge clk) begin
         if (det_clr_s[g]) begin
            chk($sformatf("clr_step_overlap%0d", g), int'(det_step_s[g]), 0);
            if (clr_q[g].size() == 0) chk($sformatf("spurious_clr%0d", g), 1, 0);
            else begin
               chk($sformatf("clr_cycle%0d", g), cyc, clr_q[g][0]);
               clr_q[g].delete(0);
            end
         end
         if (det_step_s[g]) begin
            if (step_q[g].size() == 0) chk($sformatf("spurious_step%0d", g), 1, 0);
            else begin
               chk($sformatf("step_cycle%0d", g), cyc, step_q[g][0].cyc);
               chk($sformatf("det_w%0d", g), int'(det_w_s[g]), step_q[g][0].w);
               step_q[g].delete(0);
            end
         end
         if (done_s[g] && !done_prev) begin
            if (res_q[g].size() == 0) chk($sformatf("spurious_done%0d", g), 1, 0);
            else begin
               chk($sformatf("hit_count%0d", g), int'(hc_s[g]), res_q[g][0].hc);
               chk($sformatf("first_hit%0d", g), int'(fh_s[g]), res_q[g][0].fh);
               chk($sformatf("first_valid%0d", g), int'(fv_s[g]), res_q[g][0].fv);
               chk($sformatf("done_cycle%0d", g), cyc, res_q[g][0].cyc);
               res_q[g].delete(0);
            end
         end
         done_prev <= done_s[g];
      end
   end

   task automatic push_word(input int i, input logic [W-1:0] d, input int s, input int nsteps);
      int    td;
      step_t e;
      td = (i == 0) ? 1 : 4;
      clr_q[i].push_back(s + 1);
      for (int k = 0; k < nsteps; k++) begin
         e.w   = int'(d[W-1-k]);
         e.cyc = s + 1 + td + k * (td + 1);
         step_q[i].push_back(e);
      end
   endtask

   task automatic run(input int i, input logic [W-1:0] d, input int hc, input int fh,
                      input int fv, input bit glitch);
      int   td, s;
      res_t r;
      bit   seen;
      td = (i == 0) ? 1 : 4;
      @(posedge clk); #1 start_s[i] = 1'b0;
      @(posedge clk); #1;
      data_s[i] = d;
      s = cyc;
      push_word(i, d, s, W);
      r.hc = hc; r.fh = fh; r.fv = fv; r.cyc = s + 2 + W * (td + 1);
      res_q[i].push_back(r);
      start_s[i] = 1'b1;
      @(posedge clk); #1;
      chk("start_busy", int'(busy_s[i]), 1);
      chk("start_done_clr", int'(done_s[i]), 0);
      chk("start_hc_clr", int'(hc_s[i]), 0);
      chk("start_fv_clr", int'(fv_s[i]), 0);
      if (glitch) begin
         repeat (20) @(posedge clk);
         #1 start_s[i] = 1'b0;
         data_s[i] = 16'hAAAA;
         @(posedge clk); #1 start_s[i] = 1'b1;
      end
      seen = 1'b0;
      for (int n = 0; n < 2 * W * (td + 1) + 20 && !seen; n++) begin
         @(posedge clk); #1;
         seen = done_s[i];
      end
      chk("done_timeout", int'(seen), 1);
   endtask

   task automatic chk_zero(input int i, input string tag);
      chk({tag, "_det_w"}, int'(det_w_s[i]), 0);
      chk({tag, "_det_step"}, int'(det_step_s[i]), 0);
      chk({tag, "_det_clr"}, int'(det_clr_s[i]), 0);
      chk({tag, "_busy"}, int'(busy_s[i]), 0);
      chk({tag, "_done"}, int'(done_s[i]), 0);
      chk({tag, "_hc"}, int'(hc_s[i]), 0);
      chk({tag, "_fh"}, int'(fh_s[i]), 0);
      chk({tag, "_fv"}, int'(fv_s[i]), 0);
   endtask

   initial begin
      int s, act;
      aclr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start_s[i] = 1'b0;
         data_s[i]  = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk_zero(0, "rst0");
      chk_zero(1, "rst1");
      aclr = 1'b1;

      run(0, 16'h0000, 13, 3, 1, 1'b0);
      run(0, 16'hAAAA, 0, 0, 0, 1'b0);
      run(0, 16'hF0F0, 4, 3, 1, 1'b0);
      run(1, 16'hFFFF, 13, 3, 1, 1'b1);

      // reset mid-word while SHIFT presents bit index 6
      @(posedge clk); #1 start_s[0] = 1'b0;
      @(posedge clk); #1;
      data_s[0] = 16'h0000;
      s = cyc;
      push_word(0, 16'h0000, s, 6);
      start_s[0] = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      chk("pre_abort_hc", int'(hc_s[0]), 3);
      chk("pre_abort_busy", int'(busy_s[0]), 1);
      aclr = 1'b0;
      #1;
      chk_zero(0, "abort");
      repeat (3) @(posedge clk);
      #1 aclr = 1'b1;
      act = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (busy_s[0] || det_clr_s[0] || det_step_s[0]) act++;
      end
      chk("held_start_no_restart", act, 0);

      run(0, 16'h0000, 13, 3, 1, 1'b0);
      run(0, 16'h000F, 10, 3, 1, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("leftover_steps", step_q[i].size(), 0);
         chk("leftover_clrs", clr_q[i].size(), 0);
         chk("leftover_results", res_q[i].size(), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
